// File: rtl/boss_fire_pkg.sv
// Shared types and the attack-pattern ROM for the boss fire controller.
package boss_fire_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        ARM      = 2'd2,
        HOLD     = 2'd3
    } fire_state_t;

    typedef logic [1:0] pattern_t;

    localparam int MAX_ENTRIES = 3;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_AIM   = 2'd2;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] dir;
    } entry_t;

    function automatic logic [1:0] pattern_count(input pattern_t pat);
        logic [1:0] cnt_v;
        case (pat)
            2'd0:    cnt_v = 2'd1;
            2'd1:    cnt_v = 2'd1;
            2'd2:    cnt_v = 2'd3;
            2'd3:    cnt_v = 2'd2;
            default: cnt_v = 2'd0;
        endcase
        return cnt_v;
    endfunction

    function automatic entry_t pattern_entry(input pattern_t pat, input logic [1:0] idx);
        entry_t ent_v;
        case ({pat, idx})
            4'b00_00: ent_v = '{x: 3'd0, y: 3'd3, dir: DIR_RIGHT};
            4'b01_00: ent_v = '{x: 3'd2, y: 3'd3, dir: DIR_AIM};
            4'b10_00: ent_v = '{x: 3'd2, y: 3'd2, dir: DIR_LEFT};
            4'b10_01: ent_v = '{x: 3'd0, y: 3'd3, dir: DIR_RIGHT};
            4'b10_10: ent_v = '{x: 3'd2, y: 3'd2, dir: DIR_RIGHT};
            4'b11_00: ent_v = '{x: 3'd1, y: 3'd5, dir: DIR_AIM};
            4'b11_01: ent_v = '{x: 3'd3, y: 3'd4, dir: DIR_AIM};
            default:  ent_v = '{x: 3'd0, y: 3'd0, dir: DIR_RIGHT};
        endcase
        return ent_v;
    endfunction

    function automatic logic dir_resolve(input logic [1:0] dir, input logic aim);
        logic neg_v;
        case (dir)
            DIR_LEFT: neg_v = 1'b1;
            DIR_AIM:  neg_v = aim;
            default:  neg_v = 1'b0;
        endcase
        return neg_v;
    endfunction

endpackage

// File: rtl/slot_allocator.sv
// Assigns each active pattern entry to the lowest-index slot still free.
module slot_allocator
    import boss_fire_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic [NUM_SLOTS-1:0]                  free,
    input  logic [1:0]                            entry_count,
    output logic [MAX_ENTRIES-1:0][NUM_SLOTS-1:0] slot_assign
);

    logic [NUM_SLOTS-1:0] remaining_s;
    logic                 found_s;
    logic                 take_s;
    logic                 entry_en_s;

    // Priority walk: each entry claims the first remaining free slot.
    always_comb begin
        remaining_s = free;
        slot_assign = '0;
        found_s     = 1'b0;
        take_s      = 1'b0;
        entry_en_s  = 1'b0;
        for (int e = 0; e < MAX_ENTRIES; e++) begin
            entry_en_s = (e < int'(entry_count));
            found_s    = 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                take_s            = entry_en_s & remaining_s[s] & ~found_s;
                slot_assign[e][s] = take_s;
                remaining_s[s]    = remaining_s[s] & ~take_s;
                found_s           = found_s | take_s;
            end
        end
    end

endmodule

// File: rtl/boss_fire_controller.sv
// Frame-paced volley sequencer driving the boss projectile slots.
module boss_fire_controller
    import boss_fire_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 40
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   enable,
    input  logic [9:0]             boss_x_pos,
    input  logic [9:0]             player_x_pos,
    input  logic [NUM_SLOTS-1:0]   slot_active,
    output logic [NUM_SLOTS-1:0]   shoot,
    output logic [NUM_SLOTS*3-1:0] x_step,
    output logic [NUM_SLOTS*3-1:0] y_step,
    output logic [NUM_SLOTS-1:0]   negative_x,
    output logic [1:0]             pattern,
    output logic                   busy
);

    localparam logic [5:0] CNT_RELOAD = 6'(COOLDOWN_FRAMES - 1);

    logic                                 frame_dly_r;
    logic                                 frame_tick_r;
    fire_state_t                          state_r;
    logic [5:0]                           cnt_r;
    pattern_t                             pattern_r;
    logic [NUM_SLOTS-1:0]                 shoot_r;
    logic [NUM_SLOTS-1:0][2:0]            x_step_r;
    logic [NUM_SLOTS-1:0][2:0]            y_step_r;
    logic [NUM_SLOTS-1:0]                 neg_r;
    logic                                 busy_r;

    logic [NUM_SLOTS-1:0]                 free_s;
    logic                                 aim_s;
    logic [1:0]                           entry_count_s;
    logic [MAX_ENTRIES-1:0][NUM_SLOTS-1:0] slot_assign_s;
    logic [NUM_SLOTS-1:0]                 fire_mask_s;
    entry_t [MAX_ENTRIES-1:0]             entry_s;

    assign free_s        = ~slot_active;
    assign aim_s         = (player_x_pos < boss_x_pos);
    assign entry_count_s = pattern_count(pattern_r);

    slot_allocator #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
        .free        (free_s),
        .entry_count (entry_count_s),
        .slot_assign (slot_assign_s)
    );

    // Current pattern's entries and the union of slots they claim.
    always_comb begin
        fire_mask_s = '0;
        for (int e = 0; e < MAX_ENTRIES; e++) begin
            entry_s[e]  = pattern_entry(pattern_r, 2'(e));
            fire_mask_s = fire_mask_s | slot_assign_s[e];
        end
    end

    // Rising-edge detect of frame_clk, same form the projectiles use so both see one tick cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_dly_r  <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_dly_r  <= frame_clk;
            frame_tick_r <= frame_clk & ~frame_dly_r;
        end
    end

    // Volley FSM; enable low overrides any tick so an enable drop in HOLD never advances pattern.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= IDLE;
            cnt_r     <= 6'd0;
            pattern_r <= 2'd0;
            shoot_r   <= '0;
            x_step_r  <= '0;
            y_step_r  <= '0;
            neg_r     <= '0;
            busy_r    <= 1'b0;
        end else if (!enable) begin
            state_r <= IDLE;
            shoot_r <= '0;
            busy_r  <= 1'b0;
        end else if (frame_tick_r) begin
            case (state_r)
                IDLE: begin
                    cnt_r   <= CNT_RELOAD;
                    state_r <= COOLDOWN;
                    busy_r  <= 1'b0;
                end
                COOLDOWN: begin
                    if (cnt_r == 6'd0) begin
                        state_r <= ARM;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 6'd1;
                    end
                end
                ARM: begin
                    if (|free_s) begin
                        shoot_r <= fire_mask_s;
                        state_r <= HOLD;
                        for (int s = 0; s < NUM_SLOTS; s++) begin
                            for (int e = 0; e < MAX_ENTRIES; e++) begin
                                if (slot_assign_s[e][s]) begin
                                    x_step_r[s] <= entry_s[e].x;
                                    y_step_r[s] <= entry_s[e].y;
                                    neg_r[s]    <= dir_resolve(entry_s[e].dir, aim_s);
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    shoot_r   <= '0;
                    pattern_r <= pattern_r + 2'd1;
                    cnt_r     <= CNT_RELOAD;
                    state_r   <= COOLDOWN;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    shoot_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign shoot      = shoot_r;
    assign x_step     = x_step_r;
    assign y_step     = y_step_r;
    assign negative_x = neg_r;
    assign pattern    = pattern_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_boss_fire_controller.sv
// Scoreboard bench for boss_fire_controller with a tick-level volley model.
module tb_boss_fire_controller;

    localparam int NS = 4;
    localparam int CD = 3;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            frame_clk;
    logic            enable;
    logic [9:0]      boss_x_pos;
    logic [9:0]      player_x_pos;
    logic [NS-1:0]   slot_active;
    logic [NS-1:0]   shoot;
    logic [NS*3-1:0] x_step;
    logic [NS*3-1:0] y_step;
    logic [NS-1:0]   negative_x;
    logic [1:0]      pattern;
    logic            busy;

    always #5 Clk = ~Clk;

    boss_fire_controller #(.NUM_SLOTS(NS), .COOLDOWN_FRAMES(CD)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .enable       (enable),
        .boss_x_pos   (boss_x_pos),
        .player_x_pos (player_x_pos),
        .slot_active  (slot_active),
        .shoot        (shoot),
        .x_step       (x_step),
        .y_step       (y_step),
        .negative_x   (negative_x),
        .pattern      (pattern),
        .busy         (busy)
    );

    typedef struct {
        logic [NS-1:0]   mask;
        logic [NS*3-1:0] xs;
        logic [NS*3-1:0] ys;
        logic [NS-1:0]   neg;
        logic [1:0]      pat;
        int              tick;
    } volley_t;

    volley_t exp_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int tick_num = 0;
    int volleys_seen = 0;

    // Reference model: ticks until next fire attempt, volley in flight, pattern, slot registers.
    bit              m_on = 1'b0;
    bit              m_hold = 1'b0;
    int              m_left = 0;
    int              m_pattern = 0;
    logic [NS*3-1:0] m_x = '0;
    logic [NS*3-1:0] m_y = '0;
    logic [NS-1:0]   m_neg = '0;

    // Pattern table: dir 0 = right, 1 = left, 2 = aimed at player.
    int pat_len [4]    = '{1, 1, 3, 2};
    int pat_x   [4][3] = '{'{0, 0, 0}, '{2, 0, 0}, '{2, 0, 2}, '{1, 3, 0}};
    int pat_y   [4][3] = '{'{3, 0, 0}, '{3, 0, 0}, '{2, 3, 2}, '{5, 4, 0}};
    int pat_dir [4][3] = '{'{0, 0, 0}, '{2, 0, 0}, '{1, 0, 0}, '{2, 2, 0}};

    logic [NS-1:0] prev_shoot = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (tick %0d)", name, act, req, tick_num);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_hold = 1'b0; m_left = 0; m_pattern = 0;
        m_x = '0; m_y = '0; m_neg = '0;
    endtask

    task automatic model_tick();
        logic [NS-1:0] free;
        int e;
        volley_t v;
        if (!enable) return;
        if (!m_on) begin
            m_on = 1'b1;
            m_left = CD + 1;
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_pattern = (m_pattern + 1) % 4;
            m_left = CD + 1;
        end else if (m_left > 1) begin
            m_left--;
        end else begin
            free = ~slot_active;
            if (free != '0) begin
                e = 0;
                v.mask = '0;
                for (int s = 0; s < NS; s++) begin
                    if (free[s] && e < pat_len[m_pattern]) begin
                        v.mask[s] = 1'b1;
                        m_x[s*3 +: 3] = 3'(pat_x[m_pattern][e]);
                        m_y[s*3 +: 3] = 3'(pat_y[m_pattern][e]);
                        if (pat_dir[m_pattern][e] == 2) m_neg[s] = (player_x_pos < boss_x_pos);
                        else m_neg[s] = (pat_dir[m_pattern][e] == 1);
                        e++;
                    end
                end
                v.xs = m_x; v.ys = m_y; v.neg = m_neg;
                v.pat = 2'(m_pattern); v.tick = tick_num;
                exp_q.push_back(v);
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic pre_checks();
        check("steady_x_step", 32'(x_step), 32'(m_x));
        check("steady_y_step", 32'(y_step), 32'(m_y));
        check("steady_negative_x", 32'(negative_x), 32'(m_neg));
        check("shoot_held", 32'(shoot != '0), 32'(m_hold));
        check("busy", 32'(busy), 32'(m_on && (m_hold || m_left == 1)));
        check("pattern", 32'(pattern), 32'(m_pattern));
    endtask

    task automatic tick();
        pre_checks();
        tick_num++;
        model_tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    // Tick whose processing edge coincides with enable falling.
    task automatic tick_drop();
        pre_checks();
        tick_num++;
        frame_clk = 1'b1;
        @(negedge Clk);
        enable = 1'b0;
        m_on = 1'b0;
        m_hold = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic run_to_arm(input int pat);
        int n;
        n = 0;
        while (!(m_on && !m_hold && m_left == 1 && m_pattern == pat) && n < 60) begin
            tick();
            n++;
        end
        check("reach_arm_budget", 32'(n < 60), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_shoot"}, 32'(shoot), 32'd0);
        check({tag, "_x_step"}, 32'(x_step), 32'd0);
        check({tag, "_y_step"}, 32'(y_step), 32'd0);
        check({tag, "_negative_x"}, 32'(negative_x), 32'd0);
        check({tag, "_pattern"}, 32'(pattern), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every shoot rising edge, checks release on falling edge.
    initial begin : monitor
        volley_t v;
        forever begin
            @(posedge Clk);
            #1;
            if (shoot != '0 && prev_shoot == '0) begin
                volleys_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_volley: actual shoot=%0h required no volley (tick %0d)", shoot, tick_num);
                end else begin
                    v = exp_q.pop_front();
                    check("volley_mask", 32'(shoot), 32'(v.mask));
                    check("volley_x_step", 32'(x_step), 32'(v.xs));
                    check("volley_y_step", 32'(y_step), 32'(v.ys));
                    check("volley_negative_x", 32'(negative_x), 32'(v.neg));
                    check("volley_pattern", 32'(pattern), 32'(v.pat));
                    check("volley_tick", 32'(tick_num), 32'(v.tick));
                    check("volley_busy", 32'(busy), 32'd1);
                end
            end else if (shoot == '0 && prev_shoot != '0) begin
                check("release_expected", 32'(m_hold), 32'd0);
                check("release_pattern", 32'(pattern), 32'(m_pattern));
                check("release_busy", 32'(busy), 32'd0);
            end
            prev_shoot = shoot;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : stimulus
        logic [2:0] s0_x;
        logic [2:0] s0_y;
        logic       s0_n;
        int r;

        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0;
        boss_x_pos = 10'd320; player_x_pos = 10'd100; slot_active = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("reset");

        // First volley: pattern 0 on slot 0 at tick 5, pattern 1 after tick 6.
        enable = 1'b1;
        repeat (5) tick();
        check("first_shoot", 32'(shoot), 32'b0001);
        check("first_x", 32'(x_step[2:0]), 32'd0);
        check("first_y", 32'(y_step[2:0]), 32'd3);
        tick();
        check("first_pattern_adv", 32'(pattern), 32'd1);

        // Aimed pattern, player left then right of boss.
        run_to_arm(1);
        tick();
        check("aim_left_neg", 32'(negative_x[0]), 32'd1);
        check("aim_left_x", 32'(x_step[2:0]), 32'd2);
        tick();
        player_x_pos = 10'd500;
        run_to_arm(1);
        tick();
        check("aim_right_neg", 32'(negative_x[0]), 32'd0);
        tick();

        // Spread with slot 0 busy.
        run_to_arm(2);
        slot_active = 4'b0001;
        s0_x = m_x[2:0]; s0_y = m_y[2:0]; s0_n = m_neg[0];
        tick();
        check("spread_shoot", 32'(shoot), 32'b1110);
        check("spread_x", 32'(x_step[11:3]), 32'({3'd2, 3'd0, 3'd2}));
        check("spread_y", 32'(y_step[11:3]), 32'({3'd2, 3'd3, 3'd2}));
        check("spread_neg", 32'(negative_x[3:1]), 32'b001);
        check("spread_slot0_kept", 32'({x_step[2:0], y_step[2:0], negative_x[0]}), 32'({s0_x, s0_y, s0_n}));
        slot_active = '0;
        tick();

        // All slots busy for 5 ticks, then slot 2 frees.
        run_to_arm(0);
        slot_active = 4'b1111;
        repeat (5) tick();
        slot_active = 4'b1011;
        tick();
        check("retry_shoot", 32'(shoot), 32'b0100);
        slot_active = '0;
        tick();

        // Enable drop colliding with the HOLD tick.
        run_to_arm(3);
        tick();
        tick_drop();
        check("drop_shoot", 32'(shoot), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_pattern", 32'(pattern), 32'd3);
        tick();
        enable = 1'b1;
        repeat (CD + 4) tick();

        // Reset in COOLDOWN.
        tick();
        Reset = 1'b1;
        @(negedge Clk);
        check_reset_outputs("midreset");
        model_reset();
        Reset = 1'b0;

        // Randomized phase.
        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 7);
            if (r < 3) slot_active = '0;
            else if (r < 6) slot_active = NS'($urandom);
            else if (r == 6) slot_active = '1;
            else slot_active = ~(NS'(1) << $urandom_range(0, NS - 1));
            boss_x_pos = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) player_x_pos = boss_x_pos;
            else player_x_pos = 10'($urandom_range(0, 1023));
            tick();
        end

        slot_active = '0;
        repeat (CD + 4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("volleys_enough", 32'(volleys_seen >= 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/boss_fire_controller.md
# boss_fire_controller

Upstream sequencer for the boss projectile pool. On frame ticks it runs a cooldown, picks the next attack pattern, allocates free projectile slots, and drives each slot's `shoot`, `x_step`, `y_step` and `negative_x` inputs. It sits between the boss/player position logic and the NUM_SLOTS projectile instances. Each slot's direction registers stay stable while its projectile is in flight.

## Interface
- NUM_SLOTS, 4: projectile slots driven; 3..8.
- COOLDOWN_FRAMES, 40: frame ticks between volleys; 1..63.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  vertical-sync-rate frame clock, asynchronous level.
- enable  in  1  boss alive; low forces IDLE.
- boss_x_pos  in  10  boss centre x.
- player_x_pos  in  10  player centre x.
- slot_active  in  NUM_SLOTS  1 = slot projectile in flight; supplied by the pool.
- shoot  out  NUM_SLOTS  per-slot fire request.
- x_step  out  NUM_SLOTS×3  per-slot x speed magnitude.
- y_step  out  NUM_SLOTS×3  per-slot y speed.
- negative_x  out  NUM_SLOTS  1 = slot moves left.
- pattern  out  2  pattern of the last or current volley.
- busy  out  1  high in ARM or HOLD.

## Operation
- frame_tick is a registered rising-edge detect of frame_clk: delay flop plus edge flop, the same form the projectiles use. This puts the controller and the slots on the same tick cycle.
- **States:**
  - IDLE: all shoot = 0. If enable is high at a frame_tick, load cnt = COOLDOWN_FRAMES-1 and go to COOLDOWN.
  - COOLDOWN: on each frame_tick, go to ARM if cnt == 0, otherwise decrement cnt.
  - ARM: on a frame_tick, compute free = ~slot_active.
    - If free is all zero, stay in ARM and retry at the next tick.
    - Otherwise, assign pattern entries in order to the lowest-index free slots, latch their step and direction registers, set their shoot bits, and go to HOLD.
  - HOLD: at the next frame_tick, clear shoot on the following cycle, advance pattern (mod 4), reload cnt, and go to COOLDOWN.
- enable low in any state: next state IDLE, shoot cleared next cycle, step registers retained.
- **Patterns** (entries as x_step/y_step/negative_x):
  - 0 single drop: one entry, 0/3/0.
  - 1 aimed: one entry, 2/3/aim, where aim = (player_x_pos < boss_x_pos).
  - 2 spread: three entries, 2/2/1, 0/3/0, 2/2/0.
  - 3 fast aimed pair: two entries, 1/5/aim, 3/4/aim.
- aim is sampled on the ARM→HOLD tick.
- Fewer free slots than entries: fire only the leading entries that fit. Excess entries are dropped; there is no retry.
- Unassigned slots keep their previous x_step, y_step and negative_x values unchanged.
- All arithmetic is unsigned. cnt is 6 bits. The 10-bit compare is unsigned; equal positions give aim = 0.

## Timing
- **Reset values:** state IDLE, cnt 0, pattern 0, shoot 0, x_step 0, y_step 0, negative_x 0, busy 0, edge flops 0.
- **shoot window:** shoot rises 1 cycle after the ARM tick T0 and holds through the cycle of the next tick T1, so every slot samples it at T1. It falls at T1+1.
- **Volley period:** with free slots, volleys are COOLDOWN_FRAMES + 2 ticks apart.
- **Step stability:** step registers change only on the ARM→HOLD transition cycle, and only for slots being fired.
- **enable/tick collision:** if enable falls on the same cycle as a tick in HOLD, the enable drop wins. Shoot clears and pattern does not advance.
- **slot_active rising during HOLD:** ignored; shoot stays held.

## Structure
- Package boss_fire_pkg:
  - state enum fire_state_t (IDLE, COOLDOWN, ARM, HOLD).
  - pattern_t (2-bit).
  - Pattern ROM constants as functions returning entry count and per-entry x, y, dir codes.
- Sub-module slot_allocator: combinational. Inputs are free and entry count; outputs are the one-hot assignment per entry index (lowest-index-first priority).

## Test plan
- Reset with COOLDOWN_FRAMES = 3, all slots free, enable = 1 → shoot[0] rises at tick 5 + 1 cycle with 0/3/0. It is held through tick 6, and pattern becomes 1.
- Pattern 2 with slot_active = 0b0001 → slots 1, 2, 3 fire with 2/2/1, 0/3/0, 2/2/0, and slot 0's registers are unchanged.
- All slots active in ARM for 5 ticks, then slot 2 freed → no shoot for 5 ticks, then slot 2 fires pattern entry 0 at the next tick.
- Pattern 1 with player_x_pos = 100, boss_x_pos = 320 → negative_x = 1 and x_step = 2. Repeat with player at 500 → negative_x = 0.
- enable dropped mid-HOLD → shoot = 0 next cycle, state IDLE, pattern not advanced. Re-enable → full cooldown before the next volley.
- Reset asserted during COOLDOWN → all outputs return to reset values within 1 cycle.
